simon_engine: RTL

Parametrised game core for the Simon memory game: generates a pseudo-random colour sequence, plays it back on LEDs and tone selects, checks player button presses, and tracks the level reached. It generalises the fixed 4-button game to NUM_COLORS channels, a configurable maximum level and tick-based timing. It sits between the debounced button inputs and the LED, speaker and 7-segment drivers of the top-level project. The sequence is regenerated from a stored LFSR seed on every replay, so the block needs no sequence RAM.

---
 rtl/simon_pkg.sv | 21 ++
 rtl/simon_lfsr.sv | 29 ++
 rtl/simon_engine.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon game core.
package simon_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_SHOW,
    S_INPUT,
    S_HOLD,
    S_LOSE,
    S_WIN
  } state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Raw LFSR bits span 2**CW values, which is always less than 2*n, so one subtraction suffices.
  function automatic logic [3:0] reduce_color(input logic [3:0] value, input logic [3:0] n);
    return (value >= n) ? value - n : value;
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 16-bit right-shifting Galois LFSR with seed load; an all-zero load is forced to 1.
module simon_lfsr
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] value
);

  logic [15:0] stepped;

  always_comb begin
    stepped = value[0] ? ((value >> 1) ^ LFSR_MASK) : (value >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= 16'h0001;
    end else if (load) begin
      value <= (load_val == '0) ? 16'h0001 : load_val;
    end else if (step) begin
      value <= stepped;
    end
  end

endmodule

// File: rtl/simon_engine.sv
// Simon game core: seeded sequence playback, press checking and level tracking.
module simon_engine
  import simon_pkg::*;
#(
  parameter int NUM_COLORS    = 4,
  parameter int MAX_LEVEL     = 32,
  parameter int SHOW_TICKS    = 300,
  parameter int GAP_TICKS     = 100,
  parameter int TIMEOUT_TICKS = 3000,
  localparam int CW = ($clog2(NUM_COLORS) > 1) ? $clog2(NUM_COLORS) : 1,
  localparam int LW = $clog2(MAX_LEVEL + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [NUM_COLORS-1:0] btn,
  output logic [NUM_COLORS-1:0] led,
  output logic                  tone_en,
  output logic [CW-1:0]         tone_sel,
  output logic [LW-1:0]         level,
  output logic                  game_over,
  output logic                  win
);

  localparam logic [31:0] GAP_LAST     = 32'(GAP_TICKS - 1);
  localparam logic [31:0] SHOW_LAST    = 32'(SHOW_TICKS - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_TICKS - 1);

  state_t                state, state_nx;
  logic [31:0]           tick_cnt, cnt_nx;
  logic [LW-1:0]         idx, idx_nx, level_nx;
  logic [15:0]           seed, seed_nx;
  logic                  blink, blink_nx;
  logic [NUM_COLORS-1:0] btn_q, rise, color_oh;
  logic [CW-1:0]         colour;
  logic                  lfsr_step, lfsr_load;
  logic [15:0]           lfsr_load_val, lfsr_value;

  simon_lfsr u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .step     (lfsr_step),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .value    (lfsr_value)
  );

  assign colour   = CW'(reduce_color(4'(lfsr_value[CW-1:0]), 4'(NUM_COLORS)));
  assign color_oh = NUM_COLORS'(1) << colour;
  assign rise     = btn & ~btn_q;

  always_comb begin
    state_nx      = state;
    cnt_nx        = tick_cnt;
    idx_nx        = idx;
    level_nx      = level;
    seed_nx       = seed;
    blink_nx      = blink;
    lfsr_step     = 1'b0;
    lfsr_load     = 1'b0;
    lfsr_load_val = seed;
    case (state)
      S_IDLE: begin
        lfsr_step = 1'b1;
        if (|rise) begin
          seed_nx       = lfsr_value;
          lfsr_load     = 1'b1;
          lfsr_load_val = lfsr_value;
          level_nx      = '0;
          idx_nx        = '0;
          state_nx      = S_GAP;
        end
      end
      S_GAP: begin
        if (tick) begin
          if (tick_cnt == GAP_LAST) state_nx = S_SHOW;
          else cnt_nx = tick_cnt + 32'd1;
        end
      end
      S_SHOW: begin
        if (tick) begin
          if (tick_cnt == SHOW_LAST) begin
            if (idx == level) begin
              lfsr_load = 1'b1;
              idx_nx    = '0;
              state_nx  = S_INPUT;
            end else begin
              lfsr_step = 1'b1;
              idx_nx    = idx + 1'b1;
              state_nx  = S_GAP;
            end
          end else begin
            cnt_nx = tick_cnt + 32'd1;
          end
        end
      end
      S_INPUT: begin
        if (|rise) begin
          state_nx = (rise == color_oh) ? S_HOLD : S_LOSE;
        end else if (tick) begin
          if (tick_cnt == TIMEOUT_LAST) state_nx = S_LOSE;
          else cnt_nx = tick_cnt + 32'd1;
        end
      end
      S_HOLD: begin
        if (!(|(btn & color_oh))) begin
          lfsr_step = 1'b1;
          if (idx == level) begin
            // Round complete; idx restarts rather than parking at level+1.
            level_nx = level + 1'b1;
            idx_nx   = '0;
            if (level_nx == LW'(MAX_LEVEL)) begin
              state_nx = S_WIN;
            end else begin
              lfsr_load = 1'b1;
              state_nx  = S_GAP;
            end
          end else begin
            idx_nx   = idx + 1'b1;
            state_nx = S_INPUT;
          end
        end
      end
      S_LOSE: begin
        if (|rise) state_nx = S_IDLE;
      end
      S_WIN: begin
        if (|rise) begin
          state_nx = S_IDLE;
        end else if (tick) begin
          if (tick_cnt == SHOW_LAST) begin
            cnt_nx   = '0;
            blink_nx = ~blink;
          end else begin
            cnt_nx = tick_cnt + 32'd1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (state_nx != state) begin
      cnt_nx   = '0;
      blink_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      idx      <= '0;
      level    <= '0;
      seed     <= 16'h0001;
      blink    <= 1'b0;
      btn_q    <= '0;
    end else begin
      state    <= state_nx;
      tick_cnt <= cnt_nx;
      idx      <= idx_nx;
      level    <= level_nx;
      seed     <= seed_nx;
      blink    <= blink_nx;
      btn_q    <= btn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led       <= '0;
      tone_en   <= 1'b0;
      tone_sel  <= '0;
      game_over <= 1'b0;
      win       <= 1'b0;
    end else begin
      led       <= '0;
      tone_en   <= 1'b0;
      tone_sel  <= '0;
      game_over <= 1'b0;
      win       <= 1'b0;
      case (state)
        S_SHOW, S_HOLD: begin
          led      <= color_oh;
          tone_en  <= 1'b1;
          tone_sel <= colour;
        end
        S_LOSE: begin
          led       <= '1;
          tone_en   <= 1'b1;
          game_over <= 1'b1;
        end
        S_WIN: begin
          led <= blink ? '1 : '0;
          win <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
